// File: rtl/mips_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : mips_alu_seq
// Description : Clocked MIPS ALU with a valid/ready handshake on both sides
//               and registered result/flags. Executes the R/I-type integer
//               op set at WIDTH bits. With MIPS_ALU_MULDIV_EN defined it adds
//               an iterative mult/multu/div/divu unit with HI/LO registers
//               and mfhi/mflo. Without it those six funcs decode as illegal.
// Ports       : clk, rst_n (async, active-low)
//               in_valid/in_ready   : operation handshake
//               instruction[31:0]   : opcode[31:26] sa[10:6] func[5:0] imm[15:0]
//               op_a/op_b[WIDTH]    : rs/rt operand values
//               out_valid/out_ready : result handshake
//               result[WIDTH]       : registered result
//               flags[2:0]          : {zero, negative, overflow}
// Config      : `define MIPS_ALU_MULDIV_EN enables the mult/div unit
// Revision    : 1.0 - initial release
// ============================================================================
module mips_alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags
);

    // Shift amounts are carried at 7 bits so a 5-bit sa >= WIDTH (WIDTH=16)
    // shifts everything out instead of wrapping.
    localparam int SAW = 7;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ADDIU = 6'h09;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_SLTIU = 6'h0B;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_XORI  = 6'h0E;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_SLL   = 6'h00;
    localparam logic [5:0] c_FN_SRL   = 6'h02;
    localparam logic [5:0] c_FN_SRA   = 6'h03;
    localparam logic [5:0] c_FN_SLLV  = 6'h04;
    localparam logic [5:0] c_FN_SRLV  = 6'h06;
    localparam logic [5:0] c_FN_SRAV  = 6'h07;
`ifdef MIPS_ALU_MULDIV_EN
    localparam logic [5:0] c_FN_MFHI  = 6'h10;
    localparam logic [5:0] c_FN_MFLO  = 6'h12;
    localparam logic [5:0] c_FN_MULT  = 6'h18;
    localparam logic [5:0] c_FN_MULTU = 6'h19;
    localparam logic [5:0] c_FN_DIV   = 6'h1A;
    localparam logic [5:0] c_FN_DIVU  = 6'h1B;
`endif
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_ADDU  = 6'h21;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_SUBU  = 6'h23;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_XOR   = 6'h26;
    localparam logic [5:0] c_FN_NOR   = 6'h27;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;
    localparam logic [5:0] c_FN_SLTU  = 6'h2B;

    logic [5:0]       w_opcode;
    logic [5:0]       w_func;
    logic [WIDTH-1:0] w_simm;
    logic [WIDTH-1:0] w_zimm;
    logic [SAW-1:0]   w_shamt_f;
    logic [SAW-1:0]   w_shamt_v;
    logic [WIDTH-1:0] w_sum_ab;
    logic [WIDTH-1:0] w_dif_ab;
    logic [WIDTH-1:0] w_sum_ai;
    logic             w_add_ov;
    logic             w_sub_ov;
    logic             w_addi_ov;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_accept;
    logic             w_md_start;
    logic             w_md_done;
    logic [WIDTH-1:0] w_md_lo;
    logic             w_md_ovf;
    logic             w_unused;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [2:0]       r_flags;

    assign w_opcode  = instruction[31:26];
    assign w_func    = instruction[5:0];
    assign w_simm    = WIDTH'($signed(instruction[15:0]));
    assign w_zimm    = WIDTH'(instruction[15:0]);
    assign w_shamt_f = SAW'(instruction[10:6]);
    assign w_shamt_v = SAW'(op_a[SHW-1:0]);
    // Register-number fields are resolved upstream; not needed here.
    assign w_unused  = ^instruction[25:16];

    assign w_sum_ab  = op_a + op_b;
    assign w_dif_ab  = op_a - op_b;
    assign w_sum_ai  = op_a + w_simm;
    assign w_add_ov  = (op_a[WIDTH-1] == op_b[WIDTH-1])   && (w_sum_ab[WIDTH-1] != op_a[WIDTH-1]);
    assign w_sub_ov  = (op_a[WIDTH-1] != op_b[WIDTH-1])   && (w_dif_ab[WIDTH-1] != op_a[WIDTH-1]);
    assign w_addi_ov = (op_a[WIDTH-1] == w_simm[WIDTH-1]) && (w_sum_ai[WIDTH-1] != op_a[WIDTH-1]);

    assign w_accept  = in_valid && in_ready;

`ifdef MIPS_ALU_MULDIV_EN
    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_MD_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH-1:0] r_md_p;     // mult: {acc, multiplier}; div: {rem, quotient}
    logic [WIDTH-1:0]   r_md_b;     // magnitude of multiplicand / divisor
    logic [WIDTH-1:0]   r_md_a;     // original dividend, returned in HI on /0
    logic [SHW-1:0]     r_md_cnt;
    logic               r_md_div;
    logic               r_md_neg;   // negate product / quotient at the end
    logic               r_md_negr;  // negate remainder at the end
    logic               r_md_dz;
    logic               w_md_div;
    logic               w_md_signed;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_md_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_md_hi;

    assign in_ready  = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_md_done = (r_state == S_MD_BUSY) && (r_md_cnt == SHW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_accept && w_md_start) w_state_nxt = S_MD_BUSY;
            S_MD_BUSY: if (w_md_done)              w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Signed ops iterate on magnitudes; signs are reapplied when the last
    // iteration completes, so the exit edge also loads the final values.
    assign w_a_mag = (w_md_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    assign w_b_mag = (w_md_signed && op_b[WIDTH-1]) ? -op_b : op_b;

    always_comb begin
        w_mul_sum   = {1'b0, r_md_p[2*WIDTH-1:WIDTH]} + (r_md_p[0] ? {1'b0, r_md_b} : '0);
        w_div_trial = r_md_p[2*WIDTH-1:WIDTH-1] - {1'b0, r_md_b};
        if (!r_md_div) begin
            w_md_step = {w_mul_sum, r_md_p[WIDTH-1:1]};
        end else if (w_div_trial[WIDTH]) begin
            w_md_step = {r_md_p[2*WIDTH-2:0], 1'b0};
        end else begin
            w_md_step = {w_div_trial[WIDTH-1:0], r_md_p[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        w_prod   = r_md_neg ? -w_md_step : w_md_step;
        w_md_hi  = w_prod[2*WIDTH-1:WIDTH];
        w_md_lo  = w_prod[WIDTH-1:0];
        w_md_ovf = 1'b0;
        if (r_md_div) begin
            if (r_md_dz) begin
                w_md_lo  = '1;
                w_md_hi  = r_md_a;
                w_md_ovf = 1'b1;
            end else begin
                w_md_lo = r_md_neg  ? -w_md_step[WIDTH-1:0]       : w_md_step[WIDTH-1:0];
                w_md_hi = r_md_negr ? -w_md_step[2*WIDTH-1:WIDTH] : w_md_step[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_md_p    <= '0;
            r_md_b    <= '0;
            r_md_a    <= '0;
            r_md_cnt  <= '0;
            r_md_div  <= 1'b0;
            r_md_neg  <= 1'b0;
            r_md_negr <= 1'b0;
            r_md_dz   <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            if (w_accept && w_md_start) begin
                r_md_p    <= {{WIDTH{1'b0}}, w_a_mag};
                r_md_b    <= w_b_mag;
                r_md_a    <= op_a;
                r_md_cnt  <= '0;
                r_md_div  <= w_md_div;
                r_md_neg  <= w_md_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                r_md_negr <= w_md_signed && op_a[WIDTH-1];
                r_md_dz   <= w_md_div && (op_b == '0);
            end else if (r_state == S_MD_BUSY) begin
                r_md_p   <= w_md_step;
                r_md_cnt <= r_md_cnt + 1'b1;
            end
            if (w_md_done) begin
                r_hi <= w_md_hi;
                r_lo <= w_md_lo;
            end
        end
    end
`else
    assign in_ready  = !r_out_valid || out_ready;
    assign w_md_done = 1'b0;
    assign w_md_lo   = '0;
    assign w_md_ovf  = 1'b0;
`endif

    // Decode and single-cycle execute; unlisted encodings leave result 0.
    always_comb begin
        w_res      = '0;
        w_ovf      = 1'b0;
        w_md_start = 1'b0;
`ifdef MIPS_ALU_MULDIV_EN
        w_md_div    = 1'b0;
        w_md_signed = 1'b0;
`endif
        case (w_opcode)
            c_OP_RTYPE: begin
                case (w_func)
                    c_FN_ADD:  begin w_res = w_sum_ab; w_ovf = w_add_ov; end
                    c_FN_ADDU: w_res = w_sum_ab;
                    c_FN_SUB:  begin w_res = w_dif_ab; w_ovf = w_sub_ov; end
                    c_FN_SUBU: w_res = w_dif_ab;
                    c_FN_AND:  w_res = op_a & op_b;
                    c_FN_OR:   w_res = op_a | op_b;
                    c_FN_XOR:  w_res = op_a ^ op_b;
                    c_FN_NOR:  w_res = ~(op_a | op_b);
                    c_FN_SLL:  w_res = op_b << w_shamt_f;
                    c_FN_SRL:  w_res = op_b >> w_shamt_f;
                    c_FN_SRA:  w_res = $unsigned($signed(op_b) >>> w_shamt_f);
                    c_FN_SLLV: w_res = op_b << w_shamt_v;
                    c_FN_SRLV: w_res = op_b >> w_shamt_v;
                    c_FN_SRAV: w_res = $unsigned($signed(op_b) >>> w_shamt_v);
                    c_FN_SLT:  w_res = WIDTH'($signed(op_a) < $signed(op_b));
                    c_FN_SLTU: w_res = WIDTH'(op_a < op_b);
`ifdef MIPS_ALU_MULDIV_EN
                    c_FN_MFHI: w_res = r_hi;
                    c_FN_MFLO: w_res = r_lo;
                    c_FN_MULT: begin w_md_start = 1'b1; w_md_signed = 1'b1; end
                    c_FN_MULTU: w_md_start = 1'b1;
                    c_FN_DIV:  begin w_md_start = 1'b1; w_md_div = 1'b1; w_md_signed = 1'b1; end
                    c_FN_DIVU: begin w_md_start = 1'b1; w_md_div = 1'b1; end
`endif
                    default:   w_res = '0;
                endcase
            end
            c_OP_ADDI:  begin w_res = w_sum_ai; w_ovf = w_addi_ov; end
            c_OP_ADDIU: w_res = w_sum_ai;
            c_OP_LW:    begin w_res = w_sum_ai; w_ovf = w_addi_ov; end
            c_OP_SW:    begin w_res = w_sum_ai; w_ovf = w_addi_ov; end
            c_OP_BEQ:   begin w_res = w_dif_ab; w_ovf = w_sub_ov; end
            c_OP_BNE:   begin w_res = w_dif_ab; w_ovf = w_sub_ov; end
            c_OP_SLTI:  w_res = WIDTH'($signed(op_a) < $signed(w_simm));
            c_OP_SLTIU: w_res = WIDTH'(op_a < w_simm);
            c_OP_ANDI:  w_res = op_a & w_zimm;
            c_OP_ORI:   w_res = op_a | w_zimm;
            c_OP_XORI:  w_res = op_a ^ w_zimm;
            default:    w_res = '0;
        endcase
    end

    // Output register: a single-cycle accept may coincide with a pop,
    // which keeps the pipe full; mult/div accepts just drain the old result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= 3'b000;
        end else if (w_accept && !w_md_start) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_flags     <= {(w_res == '0), w_res[WIDTH-1], w_ovf};
        end else if (w_md_done) begin
            r_out_valid <= 1'b1;
            r_result    <= w_md_lo;
            r_flags     <= {(w_md_lo == '0), w_md_lo[WIDTH-1], w_md_ovf};
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_mips_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_alu_seq
// Description : Directed table-driven bench for mips_alu_seq (WIDTH=32),
//               plus hand sequences for throughput, backpressure, mult/div
//               latency and reset during a mult/div.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [2:0]  flags;

    int n_cmp = 0;
    int n_err = 0;

    mips_alu_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .op_a        (op_a),
        .op_b        (op_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .flags       (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  fl;
    } vec_t;

    vec_t tv[$];

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] sa);
        return {6'h00, 10'h000, 5'h00, sa, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [15:0] imm);
        return {op, 10'h000, imm};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge. Returns result/flags, latency in edges (accept
    // edge counts as 1) and how many waiting cycles saw in_ready low.
    task automatic do_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic [2:0] fl,
                         output int lat, output int low);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        instruction = ins;
        op_a        = a;
        op_b        = b;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        low = 0;
        while (!out_valid && lat < 200) begin
            if (!in_ready) low++;
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", 64'(out_valid), 64'd1);
        res = result;
        fl  = flags;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [2:0]  f;
        int          lat;
        int          low;

        // name, ins, a, b, expected result, expected flags {Z,N,V}
        tv.push_back('{"add_ovf",  enc_r(6'h20, 5'd0), 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 3'b011});
        tv.push_back('{"and_clr",  enc_r(6'h24, 5'd0), 32'h000000F0, 32'h0000000F, 32'h00000000, 3'b100});
        tv.push_back('{"slt",      enc_r(6'h2A, 5'd0), 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 3'b000});
        tv.push_back('{"sltu",     enc_r(6'h2B, 5'd0), 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 3'b100});
        tv.push_back('{"sra4",     enc_r(6'h03, 5'd4), 32'h00000000, 32'h80000000, 32'hF8000000, 3'b010});
        tv.push_back('{"srlv36",   enc_r(6'h06, 5'd0), 32'h00000024, 32'h80000000, 32'h08000000, 3'b000});
        tv.push_back('{"addu",     enc_r(6'h21, 5'd0), 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 3'b010});
        tv.push_back('{"sub_ovf",  enc_r(6'h22, 5'd0), 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 3'b001});
        tv.push_back('{"subu_z",   enc_r(6'h23, 5'd0), 32'h00000005, 32'h00000005, 32'h00000000, 3'b100});
        tv.push_back('{"or",       enc_r(6'h25, 5'd0), 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 3'b000});
        tv.push_back('{"xor",      enc_r(6'h26, 5'd0), 32'hFFFF0000, 32'hFFFFFFFF, 32'h0000FFFF, 3'b000});
        tv.push_back('{"nor",      enc_r(6'h27, 5'd0), 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 3'b010});
        tv.push_back('{"sll31",    enc_r(6'h00, 5'd31), 32'h00000000, 32'h00000003, 32'h80000000, 3'b010});
        tv.push_back('{"srl8",     enc_r(6'h02, 5'd8), 32'h00000000, 32'h80000000, 32'h00800000, 3'b000});
        tv.push_back('{"sllv33",   enc_r(6'h04, 5'd0), 32'h00000021, 32'h00000001, 32'h00000002, 3'b000});
        tv.push_back('{"srav31",   enc_r(6'h07, 5'd0), 32'h0000001F, 32'h80000000, 32'hFFFFFFFF, 3'b010});
        tv.push_back('{"addi",     enc_i(6'h08, 16'hFFFF), 32'h00000005, 32'h0, 32'h00000004, 3'b000});
        tv.push_back('{"addi_ovf", enc_i(6'h08, 16'hFFFF), 32'h80000000, 32'h0, 32'h7FFFFFFF, 3'b001});
        tv.push_back('{"addiu",    enc_i(6'h09, 16'hFFFF), 32'h80000000, 32'h0, 32'h7FFFFFFF, 3'b000});
        tv.push_back('{"andi_zx",  enc_i(6'h0C, 16'h8000), 32'hFFFFFFFF, 32'h0, 32'h00008000, 3'b000});
        tv.push_back('{"ori",      enc_i(6'h0D, 16'hFFFF), 32'h00000000, 32'h0, 32'h0000FFFF, 3'b000});
        tv.push_back('{"xori",     enc_i(6'h0E, 16'h00FF), 32'hFFFFFFFF, 32'h0, 32'hFFFFFF00, 3'b010});
        tv.push_back('{"slti",     enc_i(6'h0A, 16'hFFFF), 32'hFFFFFFFE, 32'h0, 32'h00000001, 3'b000});
        tv.push_back('{"sltiu",    enc_i(6'h0B, 16'hFFFF), 32'h00000005, 32'h0, 32'h00000001, 3'b000});
        tv.push_back('{"beq",      enc_i(6'h04, 16'h0000), 32'h00000007, 32'h00000007, 32'h00000000, 3'b100});
        tv.push_back('{"bne_ovf",  enc_i(6'h05, 16'h0000), 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 3'b011});
        tv.push_back('{"lw",       enc_i(6'h23, 16'hFFFC), 32'h00001000, 32'h0, 32'h00000FFC, 3'b000});
        tv.push_back('{"sw_ovf",   enc_i(6'h2B, 16'h0001), 32'h7FFFFFFF, 32'h0, 32'h80000000, 3'b011});
        tv.push_back('{"ill_op",   enc_i(6'h3F, 16'h1234), 32'h0000007B, 32'h000001C8, 32'h00000000, 3'b100});
        tv.push_back('{"ill_fn",   enc_r(6'h01, 5'd0), 32'h0000007B, 32'h000001C8, 32'h00000000, 3'b100});
`ifndef MIPS_ALU_MULDIV_EN
        tv.push_back('{"ill_mult", enc_r(6'h18, 5'd0), 32'hFFFFFFFD, 32'h00000005, 32'h00000000, 3'b100});
        tv.push_back('{"ill_multu",enc_r(6'h19, 5'd0), 32'h00000003, 32'h00000005, 32'h00000000, 3'b100});
        tv.push_back('{"ill_div",  enc_r(6'h1A, 5'd0), 32'h00000064, 32'h00000007, 32'h00000000, 3'b100});
        tv.push_back('{"ill_divu", enc_r(6'h1B, 5'd0), 32'h00000064, 32'h00000007, 32'h00000000, 3'b100});
        tv.push_back('{"ill_mfhi", enc_r(6'h10, 5'd0), 32'h11111111, 32'h22222222, 32'h00000000, 3'b100});
        tv.push_back('{"ill_mflo", enc_r(6'h12, 5'd0), 32'h11111111, 32'h22222222, 32'h00000000, 3'b100});
`endif

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        instruction = 32'h0;
        op_a        = 32'h0;
        op_b        = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result",    64'(result),    64'd0);
        check("rst_flags",     64'(flags),     64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tv[i]) begin
            do_op(tv[i].ins, tv[i].a, tv[i].b, r, f, lat, low);
            check({tv[i].name, "_res"}, 64'(r),   64'(tv[i].res));
            check({tv[i].name, "_flg"}, 64'(f),   64'(tv[i].fl));
            check({tv[i].name, "_lat"}, 64'(lat), 64'd1);
        end

        // Back-to-back single-cycle ops with simultaneous pop/accept.
        instruction = enc_r(6'h20, 5'd0); op_a = 32'd1; op_b = 32'd2; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        check("tp_res1",   64'(result),    64'd3);
        check("tp_ready",  64'(in_ready),  64'd1);
        instruction = enc_r(6'h22, 5'd0); op_a = 32'd10; op_b = 32'd4;
        @(posedge clk); @(negedge clk);
        check("tp_res2",   64'(result),    64'd6);
        check("tp_valid2", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check("tp_drain",  64'(out_valid), 64'd0);

        // Backpressure: result held, nothing new accepted, then pop+accept.
        out_ready = 1'b0;
        instruction = enc_r(6'h26, 5'd0); op_a = 32'hFFFFFFFF; op_b = 32'h0; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        instruction = enc_r(6'h21, 5'd0); op_a = 32'd1; op_b = 32'd1;
        for (int k = 0; k < 3; k++) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_res",   64'(result),    64'hFFFFFFFF);
            check("bp_flags", 64'(flags),     64'(3'b010));
            check("bp_ready", 64'(in_ready),  64'd0);
            @(posedge clk); @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_ready_rel", 64'(in_ready), 64'd1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        check("bp_res2",   64'(result), 64'd2);
        check("bp_flags2", 64'(flags),  64'(3'b000));

`ifdef MIPS_ALU_MULDIV_EN
        do_op(enc_r(6'h18, 5'd0), 32'hFFFFFFFD, 32'd5, r, f, lat, low);
        check("mult_lo",   64'(r),   64'hFFFFFFF1);
        check("mult_flg",  64'(f),   64'(3'b010));
        check("mult_lat",  64'(lat), 64'd33);
        check("mult_busy", 64'(low), 64'd32);
        do_op(enc_r(6'h10, 5'd0), 32'h0, 32'h0, r, f, lat, low);
        check("mult_hi",   64'(r),   64'hFFFFFFFF);
        check("mfhi_lat",  64'(lat), 64'd1);

        do_op(enc_r(6'h1B, 5'd0), 32'd100, 32'd7, r, f, lat, low);
        check("divu_lo",   64'(r), 64'd14);
        check("divu_flg",  64'(f), 64'(3'b000));
        check("divu_lat",  64'(lat), 64'd33);
        do_op(enc_r(6'h10, 5'd0), 32'h0, 32'h0, r, f, lat, low);
        check("divu_hi",   64'(r), 64'd2);

        do_op(enc_r(6'h1A, 5'd0), 32'd7, 32'd0, r, f, lat, low);
        check("div0_lo",   64'(r), 64'hFFFFFFFF);
        check("div0_flg",  64'(f), 64'(3'b011));
        do_op(enc_r(6'h10, 5'd0), 32'h0, 32'h0, r, f, lat, low);
        check("div0_hi",   64'(r), 64'd7);
        check("div0_hflg", 64'(f), 64'(3'b000));

        do_op(enc_r(6'h1A, 5'd0), 32'hFFFFFFF9, 32'd2, r, f, lat, low);
        check("divs_lo",   64'(r), 64'hFFFFFFFD);
        do_op(enc_r(6'h10, 5'd0), 32'h0, 32'h0, r, f, lat, low);
        check("divs_hi",   64'(r), 64'hFFFFFFFF);

        do_op(enc_r(6'h1A, 5'd0), 32'h80000000, 32'hFFFFFFFF, r, f, lat, low);
        check("divmn_lo",  64'(r), 64'h80000000);
        check("divmn_flg", 64'(f), 64'(3'b010));
        do_op(enc_r(6'h10, 5'd0), 32'h0, 32'h0, r, f, lat, low);
        check("divmn_hi",  64'(r), 64'd0);
        check("divmn_hfl", 64'(f), 64'(3'b100));

        do_op(enc_r(6'h19, 5'd0), 32'hFFFFFFFF, 32'hFFFFFFFF, r, f, lat, low);
        check("multu_lo",  64'(r), 64'd1);
        do_op(enc_r(6'h10, 5'd0), 32'h0, 32'h0, r, f, lat, low);
        check("multu_hi",  64'(r), 64'hFFFFFFFE);
        do_op(enc_r(6'h12, 5'd0), 32'h0, 32'h0, r, f, lat, low);
        check("multu_mflo", 64'(r), 64'd1);

        // Reset in the middle of a divide.
        instruction = enc_r(6'h1B, 5'd0); op_a = 32'd100; op_b = 32'd7; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("rstmd_busy", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("rstmd_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmd_ready", 64'(in_ready), 64'd1);
        low = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) low++;
        end
        check("rstmd_no_late", 64'(low), 64'd0);
        do_op(enc_r(6'h10, 5'd0), 32'h0, 32'h0, r, f, lat, low);
        check("rstmd_hi",  64'(r), 64'd0);
        check("rstmd_hfl", 64'(f), 64'(3'b100));
        do_op(enc_r(6'h12, 5'd0), 32'h0, 32'h0, r, f, lat, low);
        check("rstmd_lo",  64'(r), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
